fetch_stage: RTL and testbench

//  Instruction fetch stage: holds PC, issues word reads to instruction memory, buffers returned

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem fetch, BUF_DEPTH-entry instruction buffer to decode.
// Latency: accepted request -> inst_valid one cycle after the imem response (outputs come from buffer regs).
// Backpressure: no request while a fetch is outstanding or the buffer is full; inst_ready=0 holds the head.
// Build option: define FETCH_ILLEGAL_CHECK_EN to add the inst_illegal opcode-check output.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      inst_opcode
`ifdef FETCH_ILLEGAL_CHECK_EN
  ,
  output logic            inst_illegal
`endif
);

  localparam int unsigned     PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;     // PC of the request currently in flight
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;         // next response belongs to a squashed fetch
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [XLEN-1:0]  buf_pc_q   [BUF_DEPTH];

  logic req_fire;
  logic rsp_take;
  logic enq;
  logic deq;

  assign imem_req_valid = !rst && !redirect_valid && !outstanding_q && (count_q < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && outstanding_q;
  assign enq            = rsp_take && !drop_q && !redirect_valid;
  assign deq            = inst_valid && inst_ready && !redirect_valid;

  // Head of the buffer drives decode; everything reads zero while the buffer is empty.
  assign inst_valid  = (count_q != '0);
  assign inst_data   = inst_valid ? buf_inst_q[rd_ptr_q] : 32'h0;
  assign inst_pc     = inst_valid ? buf_pc_q[rd_ptr_q]   : '0;
  assign inst_opcode = inst_data[6:0];

  // Next-state: redirect flushes and retargets, otherwise handshakes advance PC and buffer.
  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d          = redirect_pc & ~XLEN'(3);
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      // A response arriving now is simply discarded; one still in flight must be dropped later.
      outstanding_d = outstanding_q && !imem_rsp_valid;
      drop_d        = outstanding_q && !imem_rsp_valid;
    end else begin
      if (req_fire) begin
        outstanding_d = 1'b1;
        req_pc_d      = pc_q;
        pc_d          = pc_q + XLEN'(4);
      end
      if (rsp_take) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible once counted as valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_inst_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  // Flag head instructions outside the supported R/load/store/branch opcode set.
  always_comb begin
    inst_illegal = 1'b0;
    if (inst_valid && !rst) begin
      case (inst_opcode)
        7'b0110011,
        7'b0000011,
        7'b0100011,
        7'b1100011: inst_illegal = (inst_data[1:0] != 2'b11);
        default:    inst_illegal = 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-configurable imem model.
// Expected {pc, data} pushed on each accepted request, popped and compared on each decode pop.
// Redirect/reset clear the scoreboard so stale or flushed words show up as mismatches.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          BD     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;
`ifdef FETCH_ILLEGAL_CHECK_EN
  logic        inst_illegal;
  logic        s_ill;
`endif

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (BD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode)
`ifdef FETCH_ILLEGAL_CHECK_EN
    ,
    .inst_illegal   (inst_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_pop = 0;

  // control knobs applied at the next cycle
  logic        rst_c = 1'b1;
  logic        rdy_c = 1'b1;
  logic        irdy_c = 1'b1;
  logic        redir_c = 1'b0;
  logic [31:0] redir_pc_c = 32'h0;
  int          rsp_lat = 1;

  // imem model state (single outstanding)
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_word = 32'h0;
  logic [31:0] model_pc = RST_PC;

  // sampled DUT outputs
  logic        s_req_vld, s_ivld;
  logic [31:0] s_addr, s_ipc, s_idat;
  logic [6:0]  s_iop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0400: mem_word = 32'h0000_0013;
      32'h0000_0404: mem_word = 32'h0000_0033;
      default:       mem_word = {a[26:2], 7'h33};
    endcase
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_word;
        pend           = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
    rst            = rst_c;
    imem_req_ready = rdy_c;
    inst_ready     = irdy_c;
    redirect_valid = redir_c;
    redirect_pc    = redir_pc_c;
    redir_c        = 1'b0;
    #1;
    s_req_vld = imem_req_valid;
    s_addr    = imem_req_addr;
    s_ivld    = inst_valid;
    s_ipc     = inst_pc;
    s_idat    = inst_data;
    s_iop     = inst_opcode;
`ifdef FETCH_ILLEGAL_CHECK_EN
    s_ill     = inst_illegal;
`endif
    if (rst) begin
      sb.delete();
      model_pc       = RST_PC;
      pend           = 1'b0;
      imem_rsp_valid = 1'b0;
    end else if (redirect_valid) begin
      chk("redir_no_req", 32'(imem_req_valid), 32'd0);
      sb.delete();
      model_pc = redirect_pc & ~32'h3;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        req_log.push_back(imem_req_addr);
        e.pc  = model_pc;
        e.dat = mem_word(model_pc);
        sb.push_back(e);
        model_pc  = model_pc + 32'd4;
        pend      = 1'b1;
        pend_cnt  = rsp_lat;
        pend_word = mem_word(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        n_pop++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pop_pc", inst_pc, e.pc);
          chk("pop_data", inst_data, e.dat);
          chk("pop_opcode", 32'(inst_opcode), 32'(e.dat[6:0]));
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_c = 1'b1;
    run(2);
    rst_c = 1'b0;
  endtask

  initial begin
    int idx;
    int p0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

    // Test 1: reset state, then streaming fetch from RESET_PC
    rdy_c = 1'b1; irdy_c = 1'b1; rsp_lat = 1;
    do_reset();
    chk("rst_req_vld", 32'(s_req_vld), 32'd0);
    chk("rst_ivld", 32'(s_ivld), 32'd0);
    chk("rst_idata", s_idat, 32'd0);
    chk("rst_ipc", s_ipc, 32'd0);
    chk("rst_opcode", 32'(s_iop), 32'd0);
    idx = req_log.size();
    p0  = n_pop;
    cycle();
    chk("t1_first_req", 32'(s_req_vld), 32'd1);
    cycle();
    chk("t1_rsp_cycle_ivld", 32'(s_ivld), 32'd0);
    cycle();
    chk("t1_lat_ivld", 32'(s_ivld), 32'd1);
    chk("t1_lat_ipc", s_ipc, RST_PC);
    run(9);
    chk("t1_nreq", 32'(req_log.size() >= idx + 3), 32'd1);
    if (req_log.size() >= idx + 3) begin
      chk("t1_addr0", req_log[idx],     32'h100);
      chk("t1_addr1", req_log[idx + 1], 32'h104);
      chk("t1_addr2", req_log[idx + 2], 32'h108);
    end
    chk("t1_pops", 32'(n_pop - p0 >= 3), 32'd1);

    // Test 2: decode stalled, buffer fills to exactly BD
    do_reset();
    irdy_c = 1'b0;
    idx = req_log.size();
    run(8);
    chk("t2_nreq", 32'(req_log.size() - idx), 32'(BD));
    chk("t2_sb_size", 32'(sb.size()), 32'(BD));
    chk("t2_req_blocked", 32'(s_req_vld), 32'd0);
    chk("t2_ivld", 32'(s_ivld), 32'd1);
    chk("t2_head_pc", s_ipc, RST_PC);
    irdy_c = 1'b1;
    cycle();
    irdy_c = 1'b0;
    cycle();
    chk("t2_req_after_pop", 32'(s_req_vld), 32'd1);

    // Test 3: redirect while a request is outstanding, stale response dropped
    do_reset();
    irdy_c = 1'b0; rsp_lat = 1;
    run(2);
    rsp_lat = 3;
    cycle();
    chk("t3_pre_ivld", 32'(s_ivld), 32'd1);
    redir_c = 1'b1; redir_pc_c = 32'h0000_0203;
    idx = req_log.size();
    cycle();
    cycle();
    chk("t3_flushed", 32'(s_ivld), 32'd0);
    chk("t3_wait_stale", 32'(s_req_vld), 32'd0);
    rsp_lat = 1; irdy_c = 1'b1;
    run(10);
    chk("t3_nreq", 32'(req_log.size() > idx), 32'd1);
    if (req_log.size() > idx) chk("t3_target", req_log[idx], 32'h200);

    // Test 4: imem not ready, request held with stable address
    do_reset();
    rdy_c = 1'b0; irdy_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_req_held", 32'(s_req_vld), 32'd1);
      chk("t4_addr_stable", s_addr, RST_PC);
      chk("t4_no_ivld", 32'(s_ivld), 32'd0);
    end
    rdy_c = 1'b1;
    idx = req_log.size();
    run(4);
    chk("t4_nreq", 32'(req_log.size() > idx), 32'd1);
    if (req_log.size() > idx) chk("t4_first_addr", req_log[idx], RST_PC);

    // Test 5: reset with a full buffer
    do_reset();
    irdy_c = 1'b0;
    run(6);
    chk("t5_full", 32'(s_ivld), 32'd1);
    rst_c = 1'b1;
    cycle();
    chk("t5_rst_no_req", 32'(s_req_vld), 32'd0);
    rst_c = 1'b0;
    cycle();
    chk("t5_ivld", 32'(s_ivld), 32'd0);
    chk("t5_req_vld", 32'(s_req_vld), 32'd1);
    chk("t5_addr", s_addr, RST_PC);

    // Test 7: PC wraps past the top of the address space
    irdy_c = 1'b1;
    redir_c = 1'b1; redir_pc_c = 32'hFFFF_FFFE;
    run(2);
    idx = req_log.size();
    run(8);
    chk("t7_nreq", 32'(req_log.size() >= idx + 1), 32'd1);
    if (req_log.size() >= idx + 1) chk("t7_wrap_addr1", req_log[idx], 32'h0000_0000);
    if (idx >= 1) chk("t7_wrap_addr0", req_log[idx - 1], 32'hFFFF_FFFC);

`ifdef FETCH_ILLEGAL_CHECK_EN
    // Test 6: illegal opcode flag on the buffer head
    irdy_c = 1'b0;
    redir_c = 1'b1; redir_pc_c = 32'h0000_0400;
    cycle();
    cycle();
    chk("t6_ill_empty", 32'(s_ill), 32'd0);
    run(5);
    chk("t6_head_op", 32'(s_iop), 32'h13);
    chk("t6_ill_13", 32'(s_ill), 32'd1);
    irdy_c = 1'b1;
    cycle();
    irdy_c = 1'b0;
    cycle();
    chk("t6_head_pc", s_ipc, 32'h404);
    chk("t6_ill_33", 32'(s_ill), 32'd0);
`endif

    irdy_c = 1'b1;
    run(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
